// File: rtl/cache_bus_sram_responder.sv
// Cache-bus responder backed by a word-addressed SRAM with a fixed access latency.
// Serves single and burst reads, and strobed writes terminated by the initiator's data_last.
package cache_bus_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic        burst;
        logic        cached;
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  data_strobe;
        logic        data_ok;
        logic        data_last;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        data_ok;
        logic        data_last;
        logic [31:0] r_data;
    } cache_bus_resp_t;
endpackage

module cache_bus_sram_responder
    import cache_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int BURST_LEN   = 4,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  cache_bus_req_t  bus_req_i,
    output cache_bus_resp_t bus_resp_o,
    output logic            busy_o,
    output logic [1:0]      dbg_state_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [3:0]    LAT_LOAD  = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDATA, S_WDATA} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic          burst_q, burst_d;
    logic          mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    // Handshakes: address phase completes on valid & ready (ready only in IDLE);
    // a data beat completes on req.data_ok & resp.data_ok, and either side may stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            burst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            burst_q <= burst_d;
        end
    end

    // Memory contents survive reset; a beat landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_req_i.data_strobe[i]) begin
                    mem[idx_q][8*i +: 8] <= bus_req_i.w_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        idx_d      = idx_q;
        write_d    = write_q;
        burst_d    = burst_q;
        mem_we     = 1'b0;
        bus_resp_o = '0;

        case (state_q)
            S_IDLE: begin
                bus_resp_o.ready = 1'b1;
                if (bus_req_i.valid) begin
                    write_d = bus_req_i.write;
                    burst_d = bus_req_i.burst;
                    idx_d   = bus_req_i.addr[AW+1:2];
                    beat_d  = '0;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_LOAD;
                    end else begin
                        state_d = bus_req_i.write ? S_WDATA : S_RDATA;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = write_q ? S_WDATA : S_RDATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RDATA: begin
                bus_resp_o.data_ok   = 1'b1;
                bus_resp_o.r_data    = mem[idx_q];
                bus_resp_o.data_last = !burst_q || (beat_q == LAST_BEAT);
                if (bus_req_i.data_ok) begin
                    idx_d  = idx_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (bus_resp_o.data_last) begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                    end
                end
            end
            S_WDATA: begin
                bus_resp_o.data_ok = 1'b1;
                if (bus_req_i.data_ok) begin
                    mem_we = !rst;
                    idx_d  = idx_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (bus_req_i.data_last) begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

    logic unused_req_bits;
    assign unused_req_bits = ^{bus_req_i.cached, bus_req_i.addr[31:AW+2], bus_req_i.addr[1:0]};
endmodule

// File: tb/tb_cache_bus_sram_responder.sv
// Directed and randomized bench for cache_bus_sram_responder with a word-array reference memory.
module tb_cache_bus_sram_responder;
    import cache_bus_pkg::*;

    localparam int DEPTH = 1024;
    localparam int BLEN  = 4;
    localparam int LAT   = 2;

    logic            clk;
    logic            rst;
    cache_bus_req_t  req;
    cache_bus_resp_t resp;
    logic            busy;
    logic [1:0]      dbg_state;

    int vectors;
    int miscompares;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] wr_data [8];
    logic [3:0]  wr_strb [8];

    cache_bus_sram_responder #(
        .DEPTH_WORDS(DEPTH),
        .BURST_LEN  (BLEN),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_req_i  (req),
        .bus_resp_o (resp),
        .busy_o     (busy),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) model_mem[idx % DEPTH][8*i +: 8] = d[8*i +: 8];
    endfunction

    // Address handshake and wait for the first data beat, checking the latency.
    task automatic handshake(input logic [31:0] a, input logic wr, input logic b);
        int n;
        req.valid = 1'b1;
        req.write = wr;
        req.burst = b;
        req.cached = $urandom_range(0, 1);
        req.addr  = a;
        check("hs_ready", 32'(resp.ready), 32'd1);
        tick();
        req.valid = 1'b0;
        req.addr  = $urandom;
        check("busy_in_txn", 32'(busy), 32'd1);
        n = 1;
        while (!resp.data_ok && n < 40) begin
            check("ready_low", 32'(resp.ready), 32'd0);
            tick();
            n++;
        end
        check("first_beat_latency", 32'(n), 32'(LAT + 1));
    endtask

    // Writes nbeats beats from wr_data/wr_strb; abort_at >= 0 raises rst on that beat.
    task automatic bus_write(input logic [31:0] a, input logic b, input int nbeats, input int abort_at);
        int idx;
        idx = widx(a);
        handshake(a, 1'b1, b);
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req.data_ok = 1'b0;
                req.w_data  = $urandom;
                tick();
            end
            req.data_ok     = 1'b1;
            req.w_data      = wr_data[i];
            req.data_strobe = wr_strb[i];
            req.data_last   = (i == nbeats - 1);
            check("wbeat_data_ok", 32'(resp.data_ok), 32'd1);
            check("wbeat_last_low", 32'(resp.data_last), 32'd0);
            if (i == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                break;
            end
            tick();
            model_write(idx + i, wr_data[i], wr_strb[i]);
        end
        req.data_ok   = 1'b0;
        req.data_last = 1'b0;
        check("w_end_busy", 32'(busy), 32'd0);
        check("w_end_ready", 32'(resp.ready), 32'd1);
        check("w_end_data_ok", 32'(resp.data_ok), 32'd0);
    endtask

    // Reads one or BLEN beats; stall_cycles of initiator backpressure before beat stall_at.
    task automatic bus_read(input logic [31:0] a, input logic b, input int stall_at, input int stall_cycles);
        int idx, n;
        logic [31:0] exp_d;
        idx = widx(a);
        n = b ? BLEN : 1;
        handshake(a, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            exp_d = model_mem[(idx + i) % DEPTH];
            if (i == stall_at) begin
                req.data_ok = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    check("stall_r_data", resp.r_data, exp_d);
                    check("stall_last", 32'(resp.data_last), 32'(i == n - 1));
                    tick();
                end
            end
            req.data_ok = 1'b1;
            check("rbeat_data_ok", 32'(resp.data_ok), 32'd1);
            check("rbeat_r_data", resp.r_data, exp_d);
            check("rbeat_last", 32'(resp.data_last), 32'(i == n - 1));
            tick();
        end
        req.data_ok = 1'b0;
        check("r_end_busy", 32'(busy), 32'd0);
        check("r_end_data_ok", 32'(resp.data_ok), 32'd0);
        check("r_end_r_data", resp.r_data, 32'd0);
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_ready"}, 32'(resp.ready), 32'd1);
        check({tag, "_data_ok"}, 32'(resp.data_ok), 32'd0);
        check({tag, "_last"}, 32'(resp.data_last), 32'd0);
        check({tag, "_r_data"}, resp.r_data, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int a, nb;
        logic [31:0] rd;
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        req = '0;
        rst = 1'b1;

        // Reset, then idle for 10 cycles
        tick();
        tick();
        idle_check("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            idle_check("idle");
        end

        // Single write then read at 0x40, upper and low address bits ignored
        wr_data[0] = 32'hDEADBEEF;
        wr_strb[0] = 4'b1111;
        bus_write(32'hFFFF_F043, 1'b0, 1, -1);
        check("model_0x40", model_mem[16], 32'hDEADBEEF);
        bus_read(32'h0000_0040, 1'b0, -1, 0);

        // Byte-strobe write
        wr_data[0] = 32'h11223344;
        wr_strb[0] = 4'b1111;
        bus_write(32'h10, 1'b0, 1, -1);
        wr_data[0] = 32'hAABBCCDD;
        wr_strb[0] = 4'b0100;
        bus_write(32'h10, 1'b0, 1, -1);
        check("model_strobe", model_mem[4], 32'h11BB3344);
        bus_read(32'h10, 1'b0, -1, 0);

        // Strobe 0000 still consumes a beat and writes nothing
        wr_data[0] = 32'h0;
        wr_strb[0] = 4'b0000;
        wr_data[1] = 32'h5555AAAA;
        wr_strb[1] = 4'b1111;
        bus_write(32'h0C, 1'b1, 2, -1);
        bus_read(32'h0C, 1'b1, -1, 0);

        // Wrapping burst: words 1022,1023,0,1 hold 1..4
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 32'(i + 1);
            wr_strb[i] = 4'b1111;
        end
        bus_write(32'hFF8, 1'b1, 4, -1);
        check("wrap_model_w0", model_mem[0], 32'd3);
        bus_read(32'hFF8, 1'b1, -1, 0);

        // Backpressure at beat 2 for 3 cycles
        bus_read(32'hFF8, 1'b1, 2, 3);

        // Reset during beat 2 of a 4-beat write
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 32'hC0DE_0000 + 32'(i);
            wr_strb[i] = 4'b1111;
        end
        bus_write(32'h200, 1'b1, 4, -1);
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hBAD0_0000 + 32'(i);
        bus_write(32'h200, 1'b1, 4, 2);
        idle_check("post_abort");
        check("abort_model_b2", model_mem[130], 32'hC0DE_0002);
        bus_read(32'h200, 1'b1, -1, 0);

        // Randomized traffic in a preloaded region of words 64..79
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 4; i++) begin
                wr_data[i] = $urandom;
                wr_strb[i] = 4'b1111;
            end
            bus_write(32'(256 + blk * 16), 1'b1, 4, -1);
        end
        for (int t = 0; t < 30; t++) begin
            a = $urandom_range(64, 74);
            if ($urandom_range(0, 1) == 1) begin
                nb = $urandom_range(1, 5);
                for (int i = 0; i < nb; i++) begin
                    wr_data[i] = $urandom;
                    wr_strb[i] = 4'($urandom_range(0, 15));
                end
                bus_write(32'(a * 4) | 32'($urandom_range(0, 3)), nb > 1, nb, -1);
            end else begin
                bus_read(32'(a * 4), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                         $urandom_range(0, 2));
            end
            if ($urandom_range(0, 2) == 0) tick();
        end

        // Read-after-write back-to-back with no idle gap
        wr_data[0] = 32'h0BAD_F00D;
        wr_strb[0] = 4'b1111;
        bus_write(32'h120, 1'b0, 1, -1);
        bus_read(32'h120, 1'b0, -1, 0);
        rd = model_mem[72];
        check("raw_model", rd, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cache_bus_sram_responder.md
Name: cache_bus_sram_responder

Overview:
- Responder (slave) end of the cache bus protocol (`cache_bus_req_t` / `cache_bus_resp_t`).
- Accepts single-word and burst read/write transactions from an initiator such as the LSU or an I/D cache refill path, and services them from an internal word-addressed memory.
- Fixed, parameterised access latency.
- Used as the memory model behind core-level simulation and as the on-chip scratch RAM.

Parameters:
- DEPTH_WORDS, 1024: memory size in 32-bit words (power of 2); AW = $clog2(DEPTH_WORDS).
- BURST_LEN, 4: beats per read burst (`req.burst=1`); power of 2, ≥2.
- LATENCY, 2: idle cycles between the address handshake and the first data beat (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- bus_req_i  in  cache_bus_req_t  request: valid, write, burst, cached, addr[31:0], w_data[31:0], data_strobe[3:0], data_ok, data_last
- bus_resp_o  out  cache_bus_resp_t  response: ready, data_ok, data_last, r_data[31:0]
- busy_o  out  1  transaction in progress (state != IDLE)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high: rst sampled high at a clk edge forces state=IDLE, beat counter=0, latency counter=0.
  - Reset values: ready=1, data_ok=0, data_last=0, r_data=0, busy_o=0.
  - Memory contents are NOT reset.
- FSM states: IDLE, WAIT, RDATA, WDATA.
- IDLE:
  - ready=1 combinationally.
  - Address handshake = req.valid & ready.
  - On handshake, latch write, burst, word index = addr[AW+1:2]. addr[1:0] and upper address bits are ignored; cached is ignored.
  - Next state: WAIT if LATENCY>0 (load latency counter = LATENCY-1), else RDATA or WDATA.
- ready=0 in all other states; req.valid is ignored outside IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At 0, go to RDATA if write=0, else WDATA.
  - First data_ok is therefore asserted exactly LATENCY+1 cycles after the handshake cycle.
- RDATA:
  - data_ok=1.
  - r_data = mem[idx] combinationally; r_data=0 when data_ok=0.
  - A beat completes on req.data_ok & resp.data_ok; on completion, idx increments and the beat counter increments.
  - data_last=1 on the final beat: beat 0 for single transfers, beat BURST_LEN-1 for bursts.
  - Final beat completion: go to IDLE.
  - If req.data_ok=0, hold the beat; r_data and data_last stay stable.
- WDATA:
  - data_ok=1, data_last=0.
  - A beat completes on req.data_ok; on completion, write w_data bytes where data_strobe[i]=1 into mem[idx]. Strobe 0000 writes nothing but still counts as a beat.
  - idx increments per beat.
  - A beat with req.data_last=1 ends the transaction (go to IDLE). Beat count is not enforced for writes.
  - w_data is used as presented, with no shifting; lane alignment is the initiator's job.
- Index arithmetic:
  - idx is AW bits and wraps modulo DEPTH_WORDS (e.g. burst from the last word wraps to word 0).
  - The beat counter is $clog2(BURST_LEN) bits.
- Next-transaction timing: the cycle after the last beat is IDLE, so ready=1 and a back-to-back handshake is allowed there. There is no handshake in the same cycle as a final beat.
- Read-after-write: a read issued after a write completes returns the new data; the write is committed at the beat edge.
- Reset mid-transaction: the transaction is aborted immediately, with no further beats.
  - Memory writes from beats already completed are retained.
  - A beat coinciding with rst=1 is not written.

Test Plan:
- Reset, then idle: after rst, ready=1, data_ok=0, busy_o=0 → hold for 10 cycles with valid=0 → outputs unchanged.
- Single write then read:
  - Stimulus (LATENCY=2): write addr=0x40, w_data=0xDEADBEEF, strobe=1111, data_last=1; then read addr=0x40.
  - Response: write data_ok rises 3 cycles after handshake; read returns 0xDEADBEEF with data_last=1 on the single beat.
- Byte strobe write:
  - Stimulus: mem[0x10]=0x11223344; write w_data=0xAABBCCDD, strobe=0100; then read.
  - Response: 0x11BB3344.
- Read burst with wrap:
  - Stimulus: DEPTH_WORDS=1024, BURST_LEN=4; words 1022, 1023, 0, 1 preloaded with 1, 2, 3, 4; burst read at addr=0xFF8.
  - Response: beats 1, 2, 3, 4; data_last only on the 4th beat; busy_o=0 the next cycle.
- Initiator backpressure:
  - Stimulus: during a read burst, hold req.data_ok=0 for 3 cycles at beat 2.
  - Response: r_data/data_last stable, index not advanced, no extra beats.
- Reset mid-burst:
  - Stimulus: assert rst during beat 2 of a 4-beat write.
  - Response: beats 0–1 written, beats 2–3 not; next cycle ready=1, data_ok=0; a new read succeeds.
